// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, writable instruction memory, and a registered fetch/decode output with valid/ready.
// Memory is loaded in IDLE; in RUN it fetches one word per accepted cycle and takes branch redirects.
module instr_fetch_unit #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    input  logic                          id_ready,
    output logic                          if_valid,
    output logic [31:0]                   if_pc,
    output logic [31:0]                   if_instr,
    output logic [6:0]                    opcode,
    output logic [2:0]                    funct3,
    output logic                          halted,
    output logic                          misaligned_err
);

    localparam int AW = $clog2(IMEM_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [31:0] mem [IMEM_DEPTH];

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] instr_q, instr_d;
    logic        halted_q, halted_d;
    logic        mis_q, mis_d;

    logic        accept;
    logic        in_range;
    logic [31:0] fetch_word;

    assign accept     = !valid_q || id_ready;
    assign in_range   = {2'b00, pc_q[31:2]} < 32'(IMEM_DEPTH);
    assign fetch_word = mem[pc_q[AW+1:2]];

    // Program load only while idle; contents survive reset so a restart re-runs the same code.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        if_pc_d  = if_pc_q;
        instr_d  = instr_q;
        halted_d = halted_q;
        mis_d    = mis_q;
        case (state_q)
            S_IDLE: begin
                if (start && !prog_we) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A redirect flushes the output even when decode is stalled.
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        mis_d    = 1'b1;
                    end else begin
                        pc_d    = redirect_pc;
                        instr_d = NOP_INSTR;
                    end
                end else if (accept) begin
                    if (!in_range) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        valid_d  = 1'b0;
                    end else begin
                        instr_d = fetch_word;
                        if_pc_d = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            if_pc_q  <= 32'd0;
            instr_q  <= NOP_INSTR;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            if_pc_q  <= if_pc_d;
            instr_q  <= instr_d;
            halted_q <= halted_d;
            mis_q    <= mis_d;
        end
    end

    assign if_valid       = valid_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = instr_q;
    assign opcode         = instr_q[6:0];
    assign funct3         = instr_q[14:12];
    assign halted         = halted_q;
    assign misaligned_err = mis_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a 64-word and a 4-word instance share stimulus and are each
// compared every cycle against a behavioural model, plus directed spot checks.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic        v64, h64, e64, v4, h4, e4;
    logic [31:0] pc64, in64, pc4, in4;
    logic [6:0]  op64, op4;
    logic [2:0]  f64, f4;

    int n_assert = 0;
    int n_fail   = 0;

    instr_fetch_unit #(.IMEM_DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .if_valid(v64), .if_pc(pc64), .if_instr(in64), .opcode(op64), .funct3(f64),
        .halted(h64), .misaligned_err(e64)
    );

    instr_fetch_unit #(.IMEM_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr[1:0]), .prog_data(prog_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .if_valid(v4), .if_pc(pc4), .if_instr(in4), .opcode(op4), .funct3(f4),
        .halted(h4), .misaligned_err(e4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: "running"/"stopped" flags, the next fetch address and the visible output.
    typedef struct packed {
        logic        running;
        logic        stopped;
        logic [31:0] pc;
        logic        vld;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        mis;
    } mdl_t;

    mdl_t        m64, m4;
    logic [31:0] mm64 [64];
    logic [31:0] mm4  [4];

    function automatic mdl_t mreset();
        mdl_t r;
        r.running = 1'b0; r.stopped = 1'b0; r.pc = 32'd0; r.vld = 1'b0;
        r.ipc = 32'd0; r.instr = NOP; r.mis = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int depth, logic [31:0] rd, logic st, logic we,
                                   logic rv, logic [31:0] rpc, logic rdy);
        mdl_t n = m;
        if (!m.running && !m.stopped) begin
            if (st && !we) n.running = 1'b1;
        end else if (m.running) begin
            if (rv) begin
                n.vld = 1'b0;
                if (rpc % 4 != 0) begin
                    n.running = 1'b0; n.stopped = 1'b1; n.mis = 1'b1;
                end else begin
                    n.pc = rpc; n.instr = NOP;
                end
            end else if (!m.vld || rdy) begin
                if ((m.pc / 4) >= depth) begin
                    n.running = 1'b0; n.stopped = 1'b1; n.vld = 1'b0;
                end else begin
                    n.instr = rd; n.ipc = m.pc; n.vld = 1'b1; n.pc = m.pc + 32'd4;
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("d64.if_valid", {31'd0, v64}, {31'd0, m64.vld});
        chk("d64.if_pc", pc64, m64.ipc);
        chk("d64.if_instr", in64, m64.instr);
        chk("d64.opcode", {25'd0, op64}, {25'd0, m64.instr[6:0]});
        chk("d64.funct3", {29'd0, f64}, {29'd0, m64.instr[14:12]});
        chk("d64.halted", {31'd0, h64}, {31'd0, m64.stopped});
        chk("d64.misaligned", {31'd0, e64}, {31'd0, m64.mis});
        chk("d4.if_valid", {31'd0, v4}, {31'd0, m4.vld});
        chk("d4.if_pc", pc4, m4.ipc);
        chk("d4.if_instr", in4, m4.instr);
        chk("d4.halted", {31'd0, h4}, {31'd0, m4.stopped});
        chk("d4.misaligned", {31'd0, e4}, {31'd0, m4.mis});
    endtask

    task automatic step(input logic st, input logic we, input logic [5:0] a, input logic [31:0] d,
                        input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [31:0] rd64, rd4;
        logic        idle64, idle4;
        start = st; prog_we = we; prog_addr = a; prog_data = d;
        redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
        rd64 = ((m64.pc / 4) < 64) ? mm64[(m64.pc / 4) % 64] : 32'd0;
        rd4  = ((m4.pc / 4) < 4)   ? mm4[(m4.pc / 4) % 4]    : 32'd0;
        idle64 = !m64.running && !m64.stopped;
        idle4  = !m4.running && !m4.stopped;
        @(posedge clk);
        if (idle64 && we) mm64[a] = d;
        if (idle4 && we) mm4[a % 4] = d;
        m64 = mstep(m64, 64, rd64, st, we, rv, rpc, rdy);
        m4  = mstep(m4, 4, rd4, st, we, rv, rpc, rdy);
        #1;
        chk_all();
    endtask

    task automatic idle_step(input logic rdy);
        step(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, rdy);
    endtask

    // Called one time unit after an edge; pulses reset between edges.
    task automatic async_reset();
        #3 rst_n = 1'b0;
        m64 = mreset();
        m4  = mreset();
        #1;
        chk_all();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        m64 = mreset();
        m4  = mreset();
        #12;
        chk_all();
        rst_n = 1'b1;

        // Load filler words, then the three-instruction program last so dut4 also holds it.
        for (int i = 3; i < 64; i++) begin
            step(1'b0, 1'b1, 6'(i), $urandom, (i == 10), 32'd8, 1'b1);
        end
        step(1'b0, 1'b1, 6'd0, 32'h0050_0093, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 6'd1, 32'h0010_8113, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 6'd2, 32'hFE20_9EE3, 1'b0, 32'd0, 1'b1);
        idle_step(1'b1);
        chk("write_start_ignored", {31'd0, v64}, 32'd0);

        step(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        chk("first_cycle_not_valid", {31'd0, v64}, 32'd0);
        idle_step(1'b1);
        chk("fetch0_pc", pc64, 32'd0);
        chk("fetch0_op", {25'd0, op64}, 32'h13);
        idle_step(1'b1);
        chk("fetch1_pc", pc64, 32'd4);
        chk("fetch1_f3", {29'd0, f64}, 32'd0);
        for (int i = 0; i < 3; i++) idle_step(1'b0);
        chk("stall_pc", pc64, 32'd4);
        chk("stall_instr", in64, 32'h0010_8113);
        idle_step(1'b1);
        chk("fetch2_pc", pc64, 32'd8);
        chk("fetch2_op", {25'd0, op64}, 32'h63);
        chk("fetch2_f3", {29'd0, f64}, 32'd1);

        step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 32'd4, 1'b0);
        chk("redirect_flush_valid", {31'd0, v64}, 32'd0);
        chk("redirect_flush_instr", in64, NOP);
        idle_step(1'b0);
        chk("redirect_target_pc", pc64, 32'd4);
        chk("redirect_target_valid", {31'd0, v64}, 32'd1);

        for (int i = 0; i < 200; i++) begin
            step(($urandom % 8) == 0, ($urandom % 5) == 0, 6'($urandom), $urandom,
                 ($urandom % 10) == 0, 32'($urandom_range(0, 70)) << 2, ($urandom % 4) != 0);
        end

        async_reset();
        step(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        idle_step(1'b1);
        chk("restart_mem0", in64, 32'h0050_0093);
        idle_step(1'b1);
        idle_step(1'b1);
        idle_step(1'b1);
        chk("d4_last_pc", pc4, 32'hC);
        chk("d4_last_valid", {31'd0, v4}, 32'd1);
        idle_step(1'b1);
        chk("d4_end_halted", {31'd0, h4}, 32'd1);
        chk("d4_end_mis", {31'd0, e4}, 32'd0);
        chk("d4_end_valid", {31'd0, v4}, 32'd0);

        step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 32'd6, 1'b1);
        chk("mis_halted", {31'd0, h64}, 32'd1);
        chk("mis_err", {31'd0, e64}, 32'd1);
        chk("mis_valid", {31'd0, v64}, 32'd0);
        step(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 32'd0, 1'b1);
        step(1'b0, 1'b1, 6'd0, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1);
        idle_step(1'b1);
        chk("halt_sticky", {31'd0, h64}, 32'd1);
        chk("halt_no_valid", {31'd0, v64}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the decode/control stage. Holds the PC and a small writable instruction memory, fetches one 32-bit instruction per accepted cycle into a registered fetch/decode output with a valid/ready handshake, and accepts branch redirects from the execute stage. Exposes opcode/funct3 slices for the control unit.

Parameters:
IMEM_DEPTH, 64, instruction memory depth in 32-bit words; power of two, at least 4.
RESET_PC, 32'h0000_0000, PC value after reset; word aligned.
NOP_INSTR, 32'h0000_0013, value of if_instr after reset and after flush (addi x0,x0,0).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  in IDLE, begin fetching (one-cycle pulse sufficient)
prog_we  input  1  instruction memory write enable (IDLE only)
prog_addr  input  $clog2(IMEM_DEPTH)  word address for program load
prog_data  input  32  instruction word to load
redirect_valid  input  1  branch taken; load redirect_pc
redirect_pc  input  32  branch target byte address
id_ready  input  1  decode stage accepts if_instr this cycle
if_valid  output  1  if_instr/if_pc hold a valid fetched instruction
if_pc  output  32  byte address of if_instr
if_instr  output  32  fetched instruction
opcode  output  7  if_instr[6:0], combinational
funct3  output  3  if_instr[14:12], combinational
halted  output  1  fetch stopped (sticky until reset)
misaligned_err  output  1  halted due to misaligned redirect (sticky)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc_q=RESET_PC, if_valid=0, if_pc=0, if_instr=NOP_INSTR, halted=0, misaligned_err=0. Memory contents not reset.
- States: IDLE, RUN, HALT.
- IDLE: prog_we=1 writes mem[prog_addr]<=prog_data at clock edge. start=1 with prog_we=0 -> RUN next cycle; start with prog_we=1 -> write performed, start ignored. redirect_valid ignored.
- RUN, accept condition acc = !if_valid || id_ready.
  - Priority 1, redirect_valid=1: if redirect_pc[1:0]!=0 -> HALT, halted=1, misaligned_err=1, if_valid<=0. Else pc_q<=redirect_pc, if_valid<=0, if_instr<=NOP_INSTR (flush regardless of id_ready). Fetch from target on next acc cycle; one-cycle bubble.
  - Priority 2, acc=1 and pc_q word index (pc_q>>2) >= IMEM_DEPTH: HALT, halted=1, if_valid<=0.
  - Priority 3, acc=1: if_instr<=mem[pc_q>>2], if_pc<=pc_q, if_valid<=1, pc_q<=pc_q+4 (32-bit, wraps mod 2^32).
  - acc=0: hold pc_q, if_valid, if_pc, if_instr.
- Memory read is combinational from pc_q into the output register: latency start->first if_valid = 2 cycles (IDLE->RUN edge, then fetch edge).
- Throughput: one instruction per cycle while id_ready=1.
- HALT: terminal until reset; start, prog_we, redirect_valid ignored; if_valid=0.
- prog_we in RUN/HALT ignored (no self-modifying writes).
- Reset mid-RUN: all outputs return to reset values immediately (asynchronous), memory retained; start re-runs program from RESET_PC.

Test Plan:
- Load mem[0..2]=0x00500093,0x00108113,0xFE209EE3; start -> if_valid rises 2 cycles after start; if_pc 0,4,8 on consecutive cycles with id_ready=1; opcode 0x13,0x13,0x63; funct3 0,0,1.
- Stall: id_ready=0 for 3 cycles with if_valid=1, if_pc=4 -> if_pc/if_instr/if_valid held; on id_ready=1, next cycle if_pc=8.
- Redirect: redirect_valid=1, redirect_pc=0x4 while if_pc=8, id_ready=0 -> next cycle if_valid=0, if_instr=0x00000013; following cycle if_pc=4, if_valid=1.
- Misaligned redirect_pc=0x6 -> halted=1, misaligned_err=1, if_valid=0; subsequent start and redirect ignored.
- IMEM_DEPTH=4, run sequentially -> fetch of if_pc=0xC valid, then halted=1, misaligned_err=0, if_valid=0 once 0xC consumed.
- Assert rst_n=0 mid-RUN -> if_valid=0, if_instr=0x00000013, halted=0 without clock; after start, first fetched instruction equals previously loaded mem[0].
